sd_cmd_host: RTL
================

# sd_cmd_host

SD-card command-line host engine: the initiator side of the `mc_clk`/`mc_cmd` link, whose responder is the SD card (the `sdModel` card model in simulation). It generates the SD clock and serialises a 48-bit command with CRC7. It then receives and checks a 48-bit or 136-bit response and reports status to the register interface. The block sits inside `pframe` between the CPU-side SD controller registers and the `mc_clk_pad`/`mc_cmd_pad` pins. DAT lines are handled elsewhere.

## Interface
- `NCR_MAX`, 64: SD clock rising edges allowed between command end bit and response start bit.
- `NRC_CLKS`, 8: SD clocks inserted after each transaction before `done`.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `clk_div` in 8: SD clock half-period is `clk_div`+1 `clk` cycles. Change only while `busy`=0.
- `start` in 1: one-cycle request. Ignored while `busy`=1.
- `cmd_index` in 6: command index. Sampled on `start`.
- `cmd_arg` in 32: command argument. Sampled on `start`.
- `resp_type` in 2: response type. 00 = none; 01 = 48-bit, CRC checked; 10 = 136-bit, CRC checked; 11 = 48-bit, no CRC check (R3).
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle completion pulse.
- `resp_index` out 6: index field of a 48-bit response.
- `resp` out 128: 48-bit response: [31:0] = argument field, [127:32] = 0. 136-bit response: [127:1] = CID/CSD bits 127:1 (CRC included), [0] = 0.
- `err_timeout`, `err_crc`, `err_end` out 1 each: status flags. Valid with `done`; held until next accepted `start`.
- `mc_clk` out 1: SD clock.
- `cmd_o` out 1: CMD output data.
- `cmd_oe` out 1: CMD output enable. The pad is open-drain/tristate with pull-up.
- `cmd_i` in 1: CMD pad input.

## Operation
- Clock generator:
  - A counter runs freely whenever `rst`=0. When it reaches `clk_div`, it reloads to 0 and `mc_clk` toggles.
  - A toggle 0→1 is a rise tick; a toggle 1→0 is a fall tick.
  - The host drives CMD on fall ticks and samples `cmd_i` on rise ticks.
- FSM: IDLE → TX → (WAIT → RX) → NRC → IDLE.
- IDLE:
  - `start` latches inputs, clears all error flags, builds the 48-bit frame and sets `busy`.
  - Frame = 0, 1, index[5:0], arg[31:0], CRC7[6:0], 1, sent MSB first.
- TX:
  - On each fall tick, drive the next bit with `cmd_oe`=1. The first bit is driven on the first fall tick after `start`.
  - CRC7 uses polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits.
  - On the fall tick after the end bit: `cmd_oe`=0, `cmd_o`=1. If `resp_type`=00, go to NRC; otherwise go to WAIT.
- WAIT:
  - Count rise ticks.
  - `cmd_i`=0 sampled on a rise tick is the start bit: go to RX.
  - After `NCR_MAX` rise ticks without a start bit: set `err_timeout`, go to NRC.
- RX:
  - Shift in 47 more bits (48-bit response) or 135 more bits (136-bit response) on rise ticks. The last bit received is the end bit; it is not stored.
  - `err_end` = (end bit ≠ 1) or (transmission bit ≠ 0).
  - 48-bit CRC: covers start bit through argument (40 bits).
  - 136-bit CRC: covers CID/CSD bits 127:8. Bits 133:128 (transmission + reserved) are excluded.
  - `err_crc` = computed CRC ≠ received CRC. Forced 0 when `resp_type`=11.
  - `resp` and `resp_index` update when the end bit is sampled; a timeout leaves them unchanged. Then go to NRC.
- NRC:
  - Wait `NRC_CLKS` rise ticks with CMD released.
  - Then pulse `done`, clear `busy`, go to IDLE.

## Timing
- Reset values: `mc_clk`=0, `cmd_o`=1, `cmd_oe`=0, `busy`=0, `done`=0, `resp`=0, `resp_index`=0, all error flags 0, FSM=IDLE, divider counter=0.
- `busy` rises the cycle after `start` is accepted. `start` and `done` in the same cycle: `start` is ignored, because `busy` is still 1.
- With `clk_div`=0, `mc_clk` = `clk`/2.
- No-response command: 48 + `NRC_CLKS` SD clocks from the first fall tick to `done`.
- `done` is asserted for exactly 1 `clk` cycle, in the cycle after the final NRC rise tick.
- `rst` mid-transaction returns every output to its reset value on the next edge. CMD is released immediately.
- A start bit sampled on the `NCR_MAX`-th rise tick is accepted; no timeout is raised.

## Test plan
- CMD0, arg 0, `resp_type`=00, `clk_div`=1 → `cmd_o` serial stream 0x400000000095. `done` after 56 SD clocks; all errors 0; `cmd_oe` low afterwards.
- CMD8, arg 0x000001AA, type 01, against sdModel → stream 0x48000001AA87. `resp_index`=8, `resp[31:0]`=0x000001AA; no errors.
- CMD2, type 10, against sdModel → `resp[127:1]` equals the model CID; `err_crc`=0; `done` 8 SD clocks after the end bit.
- `cmd_i` tied 1, type 01 → `err_timeout`=1 after exactly 64 rise ticks in WAIT; `resp` unchanged; `done` pulses.
- Injected 48-bit response with one flipped CRC bit → `err_crc`=1. Same response with type 11 → `err_crc`=0. End bit forced 0 → `err_end`=1.
- `rst` asserted at bit 20 of TX → next cycle `cmd_oe`=0, `busy`=0, `mc_clk`=0. A fresh CMD0 then completes correctly.

Source files
------------

// File: rtl/sd_cmd_host.sv
// SD-card CMD-line host: generates mc_clk, shifts out a 48-bit command with CRC7,
// then captures and checks a 48- or 136-bit response before the NRC gap and done.
module sd_cmd_host #(
  parameter int NCR_MAX  = 64,
  parameter int NRC_CLKS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   clk_div,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         busy,
  output logic         done,
  output logic [5:0]   resp_index,
  output logic [127:0] resp,
  output logic         err_timeout,
  output logic         err_crc,
  output logic         err_end,
  output logic         mc_clk,
  output logic         cmd_o,
  output logic         cmd_oe,
  input  logic         cmd_i
);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_NRC} state_t;

  state_t         state_reg, state_next;
  logic [7:0]     div_cnt_reg;
  logic           mc_clk_reg;
  logic           cmd_o_reg, cmd_o_next;
  logic           cmd_oe_reg, cmd_oe_next;
  logic           busy_reg, busy_next;
  logic           done_reg, done_next;
  logic [5:0]     resp_index_reg, resp_index_next;
  logic [127:0]   resp_reg, resp_next;
  logic           err_timeout_reg, err_timeout_next;
  logic           err_crc_reg, err_crc_next;
  logic           err_end_reg, err_end_next;
  logic [47:0]    frame_reg, frame_next;
  logic [7:0]     bit_cnt_reg, bit_cnt_next;
  logic [1:0]     rtype_reg, rtype_next;
  logic [6:0]     crc_reg, crc_next;
  logic [133:0]   rx_sh_reg, rx_sh_next;

  logic           tick, rise_tick, fall_tick;
  logic [7:0]     rx_k;
  logic           rx_long, rx_last, crc_cover, rx_trans;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  function automatic logic [6:0] crc7_calc(input logic [39:0] data);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, data[i]);
    return c;
  endfunction

  // ">=" keeps the divider sane if clk_div was lowered below the running count
  assign tick      = (div_cnt_reg >= clk_div);
  assign rise_tick = tick & ~mc_clk_reg;
  assign fall_tick = tick & mc_clk_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg <= 8'd0;
      mc_clk_reg  <= 1'b0;
    end else if (tick) begin
      div_cnt_reg <= 8'd0;
      mc_clk_reg  <= ~mc_clk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 8'd1;
    end
  end

  // rx_sh_reg[j-1] holds response bit j while the frame is arriving
  assign rx_k      = bit_cnt_reg + 8'd1;
  assign rx_long   = (rtype_reg == 2'b10);
  assign rx_last   = rx_long ? (rx_k == 8'd135) : (rx_k == 8'd47);
  assign crc_cover = rx_long ? ((rx_k >= 8'd8) && (rx_k <= 8'd127)) : (rx_k <= 8'd39);
  assign rx_trans  = rx_long ? rx_sh_reg[133] : rx_sh_reg[45];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      cmd_o_reg       <= 1'b1;
      cmd_oe_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      resp_index_reg  <= 6'd0;
      resp_reg        <= 128'd0;
      err_timeout_reg <= 1'b0;
      err_crc_reg     <= 1'b0;
      err_end_reg     <= 1'b0;
      frame_reg       <= 48'd0;
      bit_cnt_reg     <= 8'd0;
      rtype_reg       <= 2'b00;
      crc_reg         <= 7'd0;
      rx_sh_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      cmd_o_reg       <= cmd_o_next;
      cmd_oe_reg      <= cmd_oe_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      resp_index_reg  <= resp_index_next;
      resp_reg        <= resp_next;
      err_timeout_reg <= err_timeout_next;
      err_crc_reg     <= err_crc_next;
      err_end_reg     <= err_end_next;
      frame_reg       <= frame_next;
      bit_cnt_reg     <= bit_cnt_next;
      rtype_reg       <= rtype_next;
      crc_reg         <= crc_next;
      rx_sh_reg       <= rx_sh_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cmd_o_next       = cmd_o_reg;
    cmd_oe_next      = cmd_oe_reg;
    busy_next        = busy_reg;
    done_next        = 1'b0;
    resp_index_next  = resp_index_reg;
    resp_next        = resp_reg;
    err_timeout_next = err_timeout_reg;
    err_crc_next     = err_crc_reg;
    err_end_next     = err_end_reg;
    frame_next       = frame_reg;
    bit_cnt_next     = bit_cnt_reg;
    rtype_next       = rtype_reg;
    crc_next         = crc_reg;
    rx_sh_next       = rx_sh_reg;
    case (state_reg)
      S_IDLE: begin
        // busy still high here means this is the done cycle: drop busy, ignore start
        if (busy_reg) begin
          busy_next = 1'b0;
        end else if (start) begin
          rtype_next       = resp_type;
          frame_next       = {2'b01, cmd_index, cmd_arg,
                              crc7_calc({2'b01, cmd_index, cmd_arg}), 1'b1};
          err_timeout_next = 1'b0;
          err_crc_next     = 1'b0;
          err_end_next     = 1'b0;
          busy_next        = 1'b1;
          bit_cnt_next     = 8'd0;
          state_next       = S_TX;
        end
      end
      S_TX: begin
        if (fall_tick) begin
          if (bit_cnt_reg == 8'd48) begin
            cmd_oe_next  = 1'b0;
            cmd_o_next   = 1'b1;
            bit_cnt_next = 8'd0;
            state_next   = (rtype_reg == 2'b00) ? S_NRC : S_WAIT;
          end else begin
            cmd_o_next   = frame_reg[47];
            cmd_oe_next  = 1'b1;
            frame_next   = {frame_reg[46:0], 1'b0};
            bit_cnt_next = bit_cnt_reg + 8'd1;
          end
        end
      end
      S_WAIT: begin
        if (rise_tick) begin
          if (!cmd_i) begin
            bit_cnt_next = 8'd0;
            crc_next     = 7'd0;
            state_next   = S_RX;
          end else if (bit_cnt_reg == 8'(NCR_MAX - 1)) begin
            err_timeout_next = 1'b1;
            bit_cnt_next     = 8'd0;
            state_next       = S_NRC;
          end else begin
            bit_cnt_next = bit_cnt_reg + 8'd1;
          end
        end
      end
      S_RX: begin
        if (rise_tick) begin
          rx_sh_next   = {rx_sh_reg[132:0], cmd_i};
          bit_cnt_next = rx_k;
          if (crc_cover) crc_next = crc7_step(crc_reg, cmd_i);
          if (rx_last) begin
            err_end_next = ~cmd_i | rx_trans;
            err_crc_next = (rtype_reg != 2'b11) && (crc_reg != rx_sh_reg[6:0]);
            if (rx_long) begin
              resp_next = {rx_sh_reg[126:0], 1'b0};
            end else begin
              resp_next       = {96'd0, rx_sh_reg[38:7]};
              resp_index_next = rx_sh_reg[44:39];
            end
            bit_cnt_next = 8'd0;
            state_next   = S_NRC;
          end
        end
      end
      S_NRC: begin
        if (rise_tick) begin
          if (bit_cnt_reg == 8'(NRC_CLKS - 1)) begin
            done_next    = 1'b1;
            bit_cnt_next = 8'd0;
            state_next   = S_IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg + 8'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign resp_index  = resp_index_reg;
  assign resp        = resp_reg;
  assign err_timeout = err_timeout_reg;
  assign err_crc     = err_crc_reg;
  assign err_end     = err_end_reg;
  assign mc_clk      = mc_clk_reg;
  assign cmd_o       = cmd_o_reg;
  // release the open-drain CMD line the moment reset is raised
  assign cmd_oe      = cmd_oe_reg & ~rst;

endmodule
